// File: rtl/racket_control.sv
// racket_control: per-player racket Y controller with button sync, movement FSM and frame-rate clamped stepping; define RACKET_ACCEL_EN for hold-to-accelerate.
module racket_control #(
  parameter int unsigned Y_MIN        = 51,
  parameter int unsigned Y_MAX        = 637,
  parameter int unsigned Y_INIT       = 344,
  parameter int unsigned STEP         = 5,
  parameter int unsigned ACCEL_FRAMES = 16
) (
  input  logic       clk65MHz,
  input  logic       rst_n,
  input  logic       end_of_frame,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       screen_idle,
  output logic [9:0] pos_of_player,
  output logic       moving
);
  typedef enum logic [1:0] {IDLE, STILL, UP, DOWN} state_t;
  state_t      state_q, state_d;
  logic [1:0]  up_sync_q, down_sync_q;
  logic        up_s, down_s;
  logic        moving_q, moving_d;
  logic [9:0]  pos_q, pos_d;
  logic [10:0] step, pos_ext, dn_sum;
  logic [9:0]  up_res, dn_res;
  assign up_s          = up_sync_q[1];
  assign down_s        = down_sync_q[1];
  assign pos_of_player = pos_q;
  assign moving        = moving_q;
  // two-flop synchronisers for the raw asynchronous buttons
  always_ff @(posedge clk65MHz or negedge rst_n) begin
    if (!rst_n) begin
      up_sync_q   <= '0;
      down_sync_q <= '0;
    end else begin
      up_sync_q   <= {up_sync_q[0], btn_up};
      down_sync_q <= {down_sync_q[0], btn_down};
    end
  end
  // movement state register with moving flag registered alongside it
  always_ff @(posedge clk65MHz or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      moving_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      moving_q <= moving_d;
    end
  end
  // next state: idle screen dominates, idle always passes through STILL, conflicting buttons mean STILL
  always_comb begin
    state_d = state_q;
    if (screen_idle)
      state_d = IDLE;
    else if (state_q == IDLE)
      state_d = STILL;
    else
      state_d = (up_s && !down_s) ? UP : (down_s && !up_s) ? DOWN : STILL;
    moving_d = (state_d == UP) || (state_d == DOWN);
  end
`ifdef RACKET_ACCEL_EN
  logic [5:0] hold_q, hold_d;
  logic       hold_clr;
  // saturating count of frames spent moving in one direction
  always_ff @(posedge clk65MHz or negedge rst_n) begin
    if (!rst_n)
      hold_q <= '0;
    else
      hold_q <= hold_d;
  end
  // clear on stopping or reversing; count only on frame pulses while moving
  always_comb begin
    hold_clr = (state_d == STILL) || (state_d == IDLE) || (moving_q && (state_d != state_q));
    hold_d   = hold_clr ? 6'd0 : (end_of_frame && moving_q && (hold_q != 6'h3f)) ? hold_q + 6'd1 : hold_q;
    step     = (32'(hold_q) >= ACCEL_FRAMES) ? 11'(2 * STEP) : 11'(STEP);
  end
`else
  logic unused_accel;
  assign unused_accel = ^32'(ACCEL_FRAMES);
  assign step         = 11'(STEP);
`endif
  // racket position register, only touched on frame pulses
  always_ff @(posedge clk65MHz or negedge rst_n) begin
    if (!rst_n)
      pos_q <= 10'(Y_INIT);
    else
      pos_q <= pos_d;
  end
  // clamped step in 11 bits; the up compare happens before subtracting so it cannot underflow
  always_comb begin
    pos_ext = {1'b0, pos_q};
    dn_sum  = pos_ext + step;
    up_res  = (pos_ext < 11'(Y_MIN) + step) ? 10'(Y_MIN) : 10'(pos_ext - step);
    dn_res  = (dn_sum > 11'(Y_MAX)) ? 10'(Y_MAX) : 10'(dn_sum);
    pos_d   = !end_of_frame       ? pos_q :
              (state_q == IDLE)   ? 10'(Y_INIT) :
              (state_q == UP)     ? up_res :
              (state_q == DOWN)   ? dn_res : pos_q;
  end
endmodule

// File: tb/tb_racket_control.sv
// tb_racket_control: directed stimulus with a queued-expectation scoreboard checked on every frame pulse and on explicit snapshots.
module tb_racket_control;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       eof = 1'b0;
  logic       bu = 1'b0;
  logic       bd = 1'b0;
  logic       si = 1'b1;
  logic [9:0] pos;
  logic       mov;
  logic       eof_seen = 1'b0;
  int         req_cnt = 0;
  int         n_cmp = 0;
  int         n_bad = 0;
  typedef struct packed {logic [9:0] p; logic m;} exp_t;
  exp_t q[$];

  always #5 clk = ~clk;

  racket_control dut (
    .clk65MHz     (clk),
    .rst_n        (rst_n),
    .end_of_frame (eof),
    .btn_up       (bu),
    .btn_down     (bd),
    .screen_idle  (si),
    .pos_of_player(pos),
    .moving       (mov)
  );

  always @(posedge clk) eof_seen <= eof;

  task automatic pop_cmp(input string nm);
    exp_t e;
    n_cmp++;
    if (q.size() == 0) begin
      n_bad++;
      $display("FAIL %s #%0d: no expectation queued, got pos=%0d moving=%0b", nm, n_cmp, pos, mov);
      return;
    end
    e = q.pop_front();
    if (pos !== e.p || mov !== e.m) begin
      n_bad++;
      $display("FAIL %s #%0d: got pos=%0d moving=%0b, want pos=%0d moving=%0b", nm, n_cmp, pos, mov, e.p, e.m);
    end
  endtask

  initial begin : monitor
    int served;
    served = 0;
    forever begin
      @(negedge clk);
      if (eof_seen) pop_cmp("frame");
      if (req_cnt != served) begin
        served++;
        pop_cmp("snap");
      end
    end
  end

  task automatic frame(input int p, input bit m);
    @(negedge clk);
    eof = 1'b1;
    q.push_back('{p: 10'(p), m: m});
    @(negedge clk);
    eof = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic snap(input int p, input bit m);
    @(posedge clk);
    #2;
    q.push_back('{p: 10'(p), m: m});
    req_cnt++;
    repeat (2) @(negedge clk);
  endtask

  task automatic press(input bit u, input bit d);
    @(negedge clk);
    bu = u;
    bd = d;
    repeat (4) @(negedge clk);
  endtask

  task automatic start();
    snap(344, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    si = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: run did not finish, compared=%0d", n_cmp);
    $fatal(1);
  end

  initial begin : stim
    start();
`ifdef RACKET_ACCEL_EN
    press(1'b0, 1'b1);
    for (int k = 1; k <= 16; k++) frame(344 + 5 * k, 1'b1);
    for (int j = 1; j <= 6; j++) frame(424 + 10 * j, 1'b1);
    press(1'b0, 1'b0);
    frame(484, 1'b0);
    press(1'b0, 1'b1);
    frame(489, 1'b1);
    frame(494, 1'b1);
`else
    for (int k = 0; k < 10; k++) frame(344, 1'b0);
    press(1'b1, 1'b0);
    for (int k = 1; k <= 20; k++) frame(344 - 5 * k, 1'b1);
    press(1'b0, 1'b0);
    frame(244, 1'b0);
    press(1'b0, 1'b1);
    for (int k = 1; k <= 80; k++) frame((244 + 5 * k > 637) ? 637 : 244 + 5 * k, 1'b1);
    press(1'b1, 1'b0);
    for (int k = 1; k <= 118; k++) frame((637 - 5 * k < 51) ? 51 : 637 - 5 * k, 1'b1);
    frame(51, 1'b1);
    press(1'b1, 1'b1);
    frame(51, 1'b0);
    press(1'b0, 1'b1);
    frame(56, 1'b1);
    frame(61, 1'b1);
    frame(66, 1'b1);
    @(negedge clk);
    si = 1'b1;
    snap(66, 1'b0);
    frame(344, 1'b0);
    @(negedge clk);
    si = 1'b0;
    repeat (3) @(negedge clk);
    frame(349, 1'b1);
    frame(354, 1'b1);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    q.push_back('{p: 10'd344, m: 1'b0});
    req_cnt++;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    frame(349, 1'b1);
`endif
    repeat (20) begin
      if (q.size() == 0) break;
      @(negedge clk);
    end
    if (q.size() != 0) begin
      $display("FAIL drain: %0d expectations never matched by a DUT output, want 0", q.size());
      n_bad += q.size();
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/racket_control.md
# racket_control

Per-player racket position controller that sits directly upstream of the ball control FSM and drives its `pos_of_player_1` / `pos_of_player_2` inputs. Each instance takes one player's up/down buttons and produces a racket top-edge Y coordinate. The coordinate is updated once per video frame and clamped to the playfield between the upper and lower bars. It also handles button synchronisation, a movement FSM and optional hold-to-accelerate.

## Interface
Parameters:
- `Y_MIN`, 51: topmost legal racket top edge (upper bar).
- `Y_MAX`, 637: bottommost legal racket top edge (717 − racket height 80).
- `Y_INIT`, 344: centred position, used at reset and in idle screen.
- `STEP`, 5: pixels moved per frame at base speed.
- `ACCEL_FRAMES`, 16: consecutive moving frames before fast speed (only with `RACKET_ACCEL_EN`).

Ports:
- `clk65MHz`, in, 1: system clock.
- `rst_n`, in, 1: reset, asynchronous, active-low.
- `end_of_frame`, in, 1: one-cycle pulse per frame.
- `btn_up`, in, 1: raw asynchronous button, move racket up (decreasing Y).
- `btn_down`, in, 1: raw asynchronous button, move racket down (increasing Y).
- `screen_idle`, in, 1: menu/idle screen active; forces the racket to centre.
- `pos_of_player`, out, 10: racket top-edge Y, registered.
- `moving`, out, 1: high while in `UP` or `DOWN`, registered.

## Operation
- Button sync:
  - `btn_up` and `btn_down` each pass through a 2-flop synchroniser.
  - Only the synchronised values `up_s` and `down_s` are used downstream.
- FSM states are `IDLE`, `STILL`, `UP`, `DOWN`. The state register updates every cycle.
  - From any state, `screen_idle`=1 goes to `IDLE`.
  - `IDLE` goes to `STILL` when `screen_idle`=0.
  - `STILL`, `UP` and `DOWN` select the next state from the synced buttons:
    - `up_s & !down_s` goes to `UP`.
    - `down_s & !up_s` goes to `DOWN`.
    - Neither or both pressed goes to `STILL`.
  - A direct `UP`↔`DOWN` change is allowed and resets the hold counter.
- Position update applies only on cycles with `end_of_frame`=1, using the current registered state:
  - `IDLE`: position set to `Y_INIT`.
  - `STILL`: position held.
  - `UP`: pos = max(pos − step, `Y_MIN`).
  - `DOWN`: pos = min(pos + step, `Y_MAX`).
- Arithmetic is done in 11 bits unsigned.
  - For `UP`, compare `pos < Y_MIN + step` before subtracting, so the result never underflows.
  - Results are truncated to 10 bits only after clamping.
- `step` is `STEP`, or 2×`STEP` when acceleration is active.
- Hold counter (6 bits, saturating):
  - Increments on each `end_of_frame` while in `UP` or `DOWN`.
  - Clears on entry to `STILL` or `IDLE`, and on a direction change.
- Without `end_of_frame`, the position never changes; `screen_idle` alone does not move it until the next frame pulse.

## Timing
- Reset values: `pos_of_player`=`Y_INIT` (344), `moving`=0, state=`IDLE`, synchronisers=0, hold counter=0.
- Button to state latency: 3 clock edges (2 synchroniser flops + state register).
- State to position: applied on the first `end_of_frame` edge after the state is registered.
- `moving` is registered alongside the state, so it is high in the same cycle the state is `UP` or `DOWN`.
- Simultaneous `end_of_frame` and a state change: position uses the old state; the new state takes effect from the next frame.
- Reset asserted mid-move: all registers return to their reset values immediately (asynchronous). Operation resumes from `IDLE` after `rst_n` deasserts.
- At a clamp boundary with the button still held: position stays at the limit, `moving` stays 1, and the hold counter keeps counting.

## Configuration
- `RACKET_ACCEL_EN` defined:
  - Once the hold counter reaches `ACCEL_FRAMES`, step = 2×`STEP`.
  - Step returns to `STEP` when the hold counter clears.
- `RACKET_ACCEL_EN` undefined:
  - The hold counter is not instantiated and step is always `STEP`.
  - `ACCEL_FRAMES` is ignored.

## Test plan
- Reset, then `screen_idle`=0 and no buttons, 10 frames -> `pos_of_player`=344 throughout, `moving`=0.
- `btn_up` held for 20 frames, accel disabled -> pos reaches 344−100=244, decreasing by 5 on each frame after the 3-cycle sync; `moving`=1.
- `btn_down` held for 80 frames, accel disabled -> pos climbs to exactly 637 and stays there; it never exceeds 637 or wraps.
- Racket at 53, `btn_up` held for 1 frame -> pos=51 (clamped, no underflow); a further frame -> still 51.
- Both buttons pressed together -> state `STILL`, pos unchanged; `screen_idle` pulsed during a move -> pos=344 on the next `end_of_frame`; `rst_n` dropped mid-frame -> pos=344 asynchronously.
- With `RACKET_ACCEL_EN`, down held from 344 -> frames 1–16 step by 5 (reaching 424), then step by 10 (434, 444, …); releasing the button for 1 frame returns the step to 5.
